// File: rtl/lexington_pkg.sv
// Shared CSR addresses, interrupt cause codes and FSM state type for the
// machine-mode interrupt controller.
package lexington_pkg;

    localparam logic [11:0] CSR_MIE = 12'h304;
    localparam logic [11:0] CSR_MIP = 12'h344;

    localparam logic [4:0] IRQ_MEI = 5'd11;
    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;

    // Implemented mie bits (MEIE, MTIE, MSIE) and the software-writable mip bit.
    localparam logic [31:0] MIE_MASK    = 32'h0000_0888;
    localparam logic [31:0] MIP_SW_MASK = 32'h0000_0008;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Fixed priority: external > software > timer.
    function automatic logic [4:0] irq_pick(input logic mei, input logic msi, input logic mti);
        logic [4:0] cause;
        cause = 5'd0;
        if (mei) begin
            cause = IRQ_MEI;
        end else if (msi) begin
            cause = IRQ_MSI;
        end else if (mti) begin
            cause = IRQ_MTI;
        end
        return cause;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level input; output is
// the last stage of the chain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q[gi] <= 1'b0;
                end else begin
                    sync_q[gi] <= sync_d[gi];
                end
            end
        end
    endgenerate

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mie/mip CSRs, fixed-priority selection
// and a request/service handshake with the trap unit.
module irq_ctrl
    import lexington_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtip_in,
    input  logic        ext_irq_in,
    input  logic        global_ie,
    input  logic        csr_rd_en,
    input  logic        csr_wr_en,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wr_data,
    output logic [31:0] csr_rd_data,
    output logic        csr_hit,
    output logic        irq_req,
    output logic [4:0]  irq_cause,
    input  logic        irq_ack,
    input  logic        mret_in
);

    logic        meip;
    logic        sel_mie;
    logic        sel_mip;
    logic [31:0] mip_val;
    logic [31:0] pending;
    logic        eligible;

    logic [31:0] mie_q,   mie_d;
    logic        msip_q,  msip_d;
    irq_state_t  state_q, state_d;
    logic [4:0]  cause_q, cause_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ext_irq_in),
        .q     (meip)
    );

    always_comb begin
        sel_mie  = (csr_addr == CSR_MIE);
        sel_mip  = (csr_addr == CSR_MIP);
        csr_hit  = sel_mie | sel_mip;
        mip_val  = {20'd0, meip, 3'd0, mtip_in, 3'd0, msip_q, 3'd0};
        pending  = mip_val & mie_q;
        eligible = global_ie && (pending != 32'd0);

        csr_rd_data = 32'd0;
        if (csr_rd_en && sel_mie) begin
            csr_rd_data = mie_q;
        end else if (csr_rd_en && sel_mip) begin
            csr_rd_data = mip_val;
        end

        // MEIP/MTIP mirror live sources; only MSIP is software-writable.
        mie_d  = mie_q;
        msip_d = msip_q;
        if (csr_wr_en && sel_mie) begin
            mie_d = csr_wr_data & MIE_MASK;
        end
        if (csr_wr_en && sel_mip) begin
            msip_d = |(csr_wr_data & MIP_SW_MASK);
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        irq_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    cause_d = irq_pick(pending[11], pending[3], pending[7]);
                    state_d = REQ;
                end
            end
            REQ: begin
                irq_req = 1'b1;
                if (irq_ack) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (mret_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        irq_cause = irq_req ? cause_q : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mie_q   <= 32'd0;
            msip_q  <= 1'b0;
            state_q <= IDLE;
            cause_q <= 5'd0;
        end else begin
            mie_q   <= mie_d;
            msip_q  <= msip_d;
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: CSR access, priority, latency, masking,
// handshake and reset abort, with hand-computed expectations.
module tb_irq_ctrl;

    localparam int SYNC = 2;
    localparam logic [11:0] A_MIE = 12'h304;
    localparam logic [11:0] A_MIP = 12'h344;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mtip_in = 1'b0;
    logic        ext_irq_in = 1'b0;
    logic        global_ie = 1'b0;
    logic        csr_rd_en = 1'b0;
    logic        csr_wr_en = 1'b0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] csr_wr_data = 32'd0;
    logic [31:0] csr_rd_data;
    logic        csr_hit;
    logic        irq_req;
    logic [4:0]  irq_cause;
    logic        irq_ack = 1'b0;
    logic        mret_in = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    irq_ctrl #(
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mtip_in     (mtip_in),
        .ext_irq_in  (ext_irq_in),
        .global_ie   (global_ie),
        .csr_rd_en   (csr_rd_en),
        .csr_wr_en   (csr_wr_en),
        .csr_addr    (csr_addr),
        .csr_wr_data (csr_wr_data),
        .csr_rd_data (csr_rd_data),
        .csr_hit     (csr_hit),
        .irq_req     (irq_req),
        .irq_cause   (irq_cause),
        .irq_ack     (irq_ack),
        .mret_in     (mret_in)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_wr_en   = 1'b1;
        csr_addr    = a;
        csr_wr_data = d;
        tick();
        csr_wr_en   = 1'b0;
        csr_wr_data = 32'd0;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        csr_rd_en = 1'b1;
        csr_addr  = a;
        #1;
        d = csr_rd_data;
        csr_rd_en = 1'b0;
    endtask

    // Ack, drop all sources while in SERVICE, let the synchroniser drain, mret.
    task automatic finish_service;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        mtip_in = 1'b0;
        ext_irq_in = 1'b0;
        csr_wr(A_MIP, 32'd0);
        repeat (SYNC + 1) tick();
        mret_in = 1'b1;
        tick();
        mret_in = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({irq_req, irq_cause} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_req: req/cause=%b/%0d expected 0/0", irq_req, irq_cause);
        end
        csr_addr = A_MIE;
        #1;
        n_tests++;
        if ({csr_hit, csr_rd_data} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_noread: hit=%b rd=%h expected 1/00000000", csr_hit, csr_rd_data);
        end
        rst_n = 1'b1;
        tick();
        csr_rd(A_MIE, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mie: got %h expected 00000000", rd);
        end
        csr_rd(A_MIP, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mip: got %h expected 00000000", rd);
        end
        csr_addr = 12'h300;
        #1;
        n_tests++;
        if (csr_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_other: got %b expected 0", csr_hit);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_csr_access;
        logic [31:0] rd;
        csr_wr(A_MIP, 32'hFFFF_FFFF);
        csr_rd(A_MIP, rd);
        n_tests++;
        if (rd !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL mip_write: got %h expected 00000008", rd);
        end
        mtip_in = 1'b1;
        csr_rd(A_MIP, rd);
        n_tests++;
        if (rd !== 32'h0000_0088) begin
            n_fail++;
            $display("FAIL mip_live_mtip: got %h expected 00000088", rd);
        end
        mtip_in = 1'b0;
        csr_wr(A_MIE, 32'hFFFF_FFFF);
        csr_rd(A_MIE, rd);
        n_tests++;
        if (rd !== 32'h0000_0888) begin
            n_fail++;
            $display("FAIL mie_write: got %h expected 00000888", rd);
        end
        csr_rd_en = 1'b1;
        csr_addr  = 12'h305;
        #1;
        n_tests++;
        if ({csr_hit, csr_rd_data} !== {1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL rd_unmapped: hit=%b rd=%h expected 0/00000000", csr_hit, csr_rd_data);
        end
        csr_rd_en = 1'b0;
        csr_wr(A_MIP, 32'd0);
        csr_rd(A_MIP, rd);
        n_tests++;
        if ({rd, irq_req} !== {32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL msip_clear: mip=%h req=%b expected 00000000/0", rd, irq_req);
        end
        $display("[TB] test_csr_access done");
    endtask

    task automatic test_mtip;
        global_ie = 1'b1;
        mtip_in = 1'b1;
        #1;
        n_tests++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mtip_pre_edge: req=%b expected 0", irq_req);
        end
        tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd7}) begin
            n_fail++;
            $display("FAIL mtip_req: req/cause=%b/%0d expected 1/7", irq_req, irq_cause);
        end
        repeat (3) tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd7}) begin
            n_fail++;
            $display("FAIL mtip_hold: req/cause=%b/%0d expected 1/7", irq_req, irq_cause);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mtip_service: req=%b expected 0", irq_req);
        end
        mret_in = 1'b1;
        tick();
        mret_in = 1'b0;
        n_tests++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mtip_idle_gap: req=%b expected 0", irq_req);
        end
        tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd7}) begin
            n_fail++;
            $display("FAIL mtip_rereq: req/cause=%b/%0d expected 1/7", irq_req, irq_cause);
        end
        finish_service();
        $display("[TB] test_mtip done");
    endtask

    task automatic test_priority;
        ext_irq_in = 1'b1;
        mtip_in = 1'b1;
        tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd7}) begin
            n_fail++;
            $display("FAIL prio_first: req/cause=%b/%0d expected 1/7", irq_req, irq_cause);
        end
        repeat (SYNC + 1) tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd7}) begin
            n_fail++;
            $display("FAIL prio_no_preempt: req/cause=%b/%0d expected 1/7", irq_req, irq_cause);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        mret_in = 1'b1;
        tick();
        mret_in = 1'b0;
        tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd11}) begin
            n_fail++;
            $display("FAIL prio_mei: req/cause=%b/%0d expected 1/11", irq_req, irq_cause);
        end
        finish_service();
        $display("[TB] test_priority done");
    endtask

    task automatic test_ext_latency;
        logic [31:0] rd;
        ext_irq_in = 1'b1;
        tick();
        csr_rd(A_MIP, rd);
        n_tests++;
        if ({rd, irq_req} !== {32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL ext_edge1: mip=%h req=%b expected 00000000/0", rd, irq_req);
        end
        tick();
        csr_rd(A_MIP, rd);
        n_tests++;
        if ({rd, irq_req} !== {32'h0000_0800, 1'b0}) begin
            n_fail++;
            $display("FAIL ext_edge2: mip=%h req=%b expected 00000800/0", rd, irq_req);
        end
        tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd11}) begin
            n_fail++;
            $display("FAIL ext_req: req/cause=%b/%0d expected 1/11", irq_req, irq_cause);
        end
        ext_irq_in = 1'b0;
        csr_wr(A_MIE, 32'd0);
        repeat (SYNC + 2) tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd11}) begin
            n_fail++;
            $display("FAIL ext_hold: req/cause=%b/%0d expected 1/11", irq_req, irq_cause);
        end
        finish_service();
        n_tests++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_after: req=%b expected 0", irq_req);
        end
        $display("[TB] test_ext_latency done");
    endtask

    task automatic test_msip_same_cycle;
        csr_wr(A_MIE, 32'h0000_0008);
        csr_wr(A_MIP, 32'h0000_0008);
        n_tests++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL msip_prewrite: req=%b expected 0", irq_req);
        end
        tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd3}) begin
            n_fail++;
            $display("FAIL msip_req: req/cause=%b/%0d expected 1/3", irq_req, irq_cause);
        end
        finish_service();
        $display("[TB] test_msip_same_cycle done");
    endtask

    task automatic test_global_ie;
        int bad;
        global_ie = 1'b0;
        csr_wr(A_MIE, 32'h0000_0008);
        csr_wr(A_MIP, 32'h0000_0008);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (irq_req !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL gie_masked: req high in %0d of 10 cycles expected 0", bad);
        end
        global_ie = 1'b1;
        tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd3}) begin
            n_fail++;
            $display("FAIL gie_req: req/cause=%b/%0d expected 1/3", irq_req, irq_cause);
        end
        $display("[TB] test_global_ie done");
    endtask

    task automatic test_ignored_strobes;
        mret_in = 1'b1;
        tick();
        mret_in = 1'b0;
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd3}) begin
            n_fail++;
            $display("FAIL mret_in_req: req/cause=%b/%0d expected 1/3", irq_req, irq_cause);
        end
        irq_ack = 1'b1;
        tick();
        tick();
        irq_ack = 1'b0;
        n_tests++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_in_service: req=%b expected 0", irq_req);
        end
        $display("[TB] test_ignored_strobes done");
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if ({irq_req, irq_cause} !== 6'd0) begin
            n_fail++;
            $display("FAIL abort_req: req/cause=%b/%0d expected 0/0", irq_req, irq_cause);
        end
        csr_rd(A_MIE, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_mie: got %h expected 00000000", rd);
        end
        csr_rd(A_MIP, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_msip: got %h expected 00000000", rd);
        end
        mret_in = 1'b1;
        tick();
        mret_in = 1'b0;
        n_tests++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_mret: req=%b expected 0", irq_req);
        end
        mtip_in = 1'b1;
        csr_wr(A_MIE, 32'h0000_0080);
        tick();
        n_tests++;
        if ({irq_req, irq_cause} !== {1'b1, 5'd7}) begin
            n_fail++;
            $display("FAIL abort_idle: req/cause=%b/%0d expected 1/7", irq_req, irq_cause);
        end
        finish_service();
        $display("[TB] test_reset_abort done");
    endtask

    initial begin
        test_reset();
        test_csr_access();
        test_mtip();
        test_priority();
        test_ext_latency();
        test_msip_same_cycle();
        test_global_ie();
        test_ignored_strobes();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
